// File: rtl/mul32_seq_ctrl.sv
// Sequenced unsigned 32x32->64 multiply built on one shared external 8x8 multiplier.
// Byte pairs are steered out, and the returned 16-bit partial products are accumulated with shifts.
module mul32_seq_ctrl #(
  parameter int unsigned UUID        = 0,
  parameter bit          SKIP_ZERO_B = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        busy,
  output logic [7:0]  mul_in0,
  output logic [7:0]  mul_in1,
  input  logic [7:0]  mul_out0,
  input  logic [7:0]  mul_out1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [3:0]  idx;
  logic [3:0]  last_idx;
  logic [3:0]  last_idx_d;
  logic [63:0] acc;
  logic [31:0] a_q, b_q;
  logic        accept;
  logic        b_empty;
  logic [1:0]  top_row;
  logic [2:0]  shift_bytes;
  logic [63:0] partial;

  assign accept = (state == IDLE) && in_valid && !abort;

  // The last row processed is the highest nonzero b byte when skipping, otherwise row 3.
  // A zero b with skipping enabled needs no rows at all, so it goes straight to DONE.
  always_comb begin
    top_row = 2'd0;
    b_empty = 1'b0;
    if (SKIP_ZERO_B) begin
      if (in_b[31:24] != 8'd0)      top_row = 2'd3;
      else if (in_b[23:16] != 8'd0) top_row = 2'd2;
      else if (in_b[15:8] != 8'd0)  top_row = 2'd1;
      else begin
        top_row = 2'd0;
        b_empty = (in_b[7:0] == 8'd0);
      end
    end else begin
      top_row = 2'd3;
    end
    last_idx_d = {top_row, 2'b11};
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept) state_d = b_empty ? DONE : RUN;
      RUN: begin
        if (abort)                state_d = IDLE;
        else if (idx == last_idx) state_d = DONE;
      end
      DONE: if (abort || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  assign shift_bytes = {1'b0, idx[1:0]} + {1'b0, idx[3:2]};
  assign partial     = {48'd0, mul_out1, mul_out0} << {shift_bytes, 3'b000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx      <= '0;
      last_idx <= '0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            acc      <= '0;
            idx      <= '0;
            last_idx <= last_idx_d;
          end
        end
        RUN: begin
          if (abort) begin
            acc <= '0;
            idx <= '0;
          end else begin
            acc <= acc + partial;
            idx <= idx + 4'd1;
          end
        end
        DONE: if (abort) acc <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    mul_in0 = '0;
    mul_in1 = '0;
    if (state == RUN) begin
      mul_in0 = a_q[{idx[1:0], 3'b000} +: 8];
      mul_in1 = b_q[{idx[3:2], 3'b000} +: 8];
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state == RUN) || (state == DONE);
  assign out_valid  = (state == DONE);
  assign out_result = acc;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl: one instance without and one with zero-row skipping,
// each served by a behavioural 8x8 multiplier; results are checked through a queue scoreboard.
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, iv0, iv1, abort, out_ready, sel;
  logic [31:0] in_a, in_b;

  logic        ir0, ov0, bz0, ir1, ov1, bz1;
  logic [63:0] res0, res1;
  logic [7:0]  mi0_0, mi1_0, mo0_0, mo1_0;
  logic [7:0]  mi0_1, mi1_1, mo0_1, mo1_1;

  assign {mo1_0, mo0_0} = {8'd0, mi0_0} * {8'd0, mi1_0};
  assign {mo1_1, mo0_1} = {8'd0, mi0_1} * {8'd0, mi1_1};

  mul32_seq_ctrl #(.UUID(0), .SKIP_ZERO_B(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(iv0), .in_ready(ir0), .in_a(in_a), .in_b(in_b),
    .abort(abort), .out_valid(ov0), .out_ready(out_ready), .out_result(res0), .busy(bz0),
    .mul_in0(mi0_0), .mul_in1(mi1_0), .mul_out0(mo0_0), .mul_out1(mo1_0)
  );

  mul32_seq_ctrl #(.UUID(1), .SKIP_ZERO_B(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(iv1), .in_ready(ir1), .in_a(in_a), .in_b(in_b),
    .abort(abort), .out_valid(ov1), .out_ready(out_ready), .out_result(res1), .busy(bz1),
    .mul_in0(mi0_1), .mul_in1(mi1_1), .mul_out0(mo0_1), .mul_out1(mo1_1)
  );

  // Observation view of whichever instance is under test.
  logic        ir, ov, bz;
  logic [63:0] res;
  logic [7:0]  mi0, mi1;
  assign ir  = sel ? ir1 : ir0;
  assign ov  = sel ? ov1 : ov0;
  assign bz  = sel ? bz1 : bz0;
  assign res = sel ? res1 : res0;
  assign mi0 = sel ? mi0_1 : mi0_0;
  assign mi1 = sel ? mi1_1 : mi1_0;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;
  logic [63:0] discard;
  logic [31:0] cur_a, cur_b;
  logic        seen_valid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rows(input logic [31:0] b, input logic skip);
    if (!skip) return 4;
    for (int r = 3; r >= 0; r--)
      if (b[8*r +: 8] != 8'd0) return r + 1;
    return 0;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    cur_a = a;
    cur_b = b;
    exp_q.push_back({32'd0, a} * {32'd0, b});
    in_a = a;
    in_b = b;
    if (sel) iv1 = 1'b1; else iv0 = 1'b1;
    step();
    iv0 = 1'b0;
    iv1 = 1'b0;
    check("ready_low_after_accept", 64'(ir), 64'd0);
  endtask

  // Latency counts edges after the accept edge; with no rows the result is already valid there.
  task automatic wait_done();
    int unsigned k;
    int unsigned cyc;
    k   = rows(cur_b, sel);
    cyc = 0;
    while (!ov && cyc < 40) begin
      if (cyc < 16) begin
        check("mul_in0", 64'(mi0), 64'(cur_a[8*(cyc%4) +: 8]));
        check("mul_in1", 64'(mi1), 64'(cur_b[8*(cyc/4) +: 8]));
      end
      check("busy_run", 64'(bz), 64'd1);
      step();
      cyc++;
    end
    check("latency", 64'(cyc), 64'(4*k));
    if (exp_q.size() == 0) begin
      last_exp = 'x;
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      last_exp = exp_q.pop_front();
    end
    check("result", res, last_exp);
  endtask

  task automatic finish_op(input int unsigned hold);
    for (int unsigned h = 0; h < hold; h++) begin
      check("hold_valid", 64'(ov), 64'd1);
      check("hold_result", res, last_exp);
      check("hold_ready_low", 64'(ir), 64'd0);
      step();
    end
    iv0 = 1'b0;
    iv1 = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_after_handshake", 64'(ov), 64'd0);
    check("ready_after_handshake", 64'(ir), 64'd1);
    check("busy_after_handshake", 64'(bz), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; iv0 = 1'b1; iv1 = 1'b0; abort = 1'b0; out_ready = 1'b0; sel = 1'b0;
    in_a = 32'd3; in_b = 32'd5;
    #3;
    check("rst_ready", 64'(ir0), 64'd1);
    check("rst_valid", 64'(ov0), 64'd0);
    check("rst_busy", 64'(bz0), 64'd0);
    check("rst_result", res0, 64'd0);
    check("rst_mul_in0", 64'(mi0_0), 64'd0);
    check("rst_mul_in1", 64'(mi1_0), 64'd0);
    check("rst_ready_skip", 64'(ir1), 64'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    start_op(32'd3, 32'd5);
    wait_done();
    finish_op(0);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    finish_op(0);

    // Operand change and a spurious request while busy must not disturb the result.
    start_op(32'h0001_0000, 32'h0001_0000);
    in_a = 32'd7; in_b = 32'd9; iv0 = 1'b1;
    wait_done();
    finish_op(5);

    sel = 1'b1;
    start_op(32'h1234_5678, 32'h0000_0005);
    wait_done();
    finish_op(0);
    start_op(32'hABCD_EF01, 32'h0000_0000);
    wait_done();
    finish_op(0);
    start_op(32'h1234_5678, 32'h0001_0000);
    wait_done();
    finish_op(1);
    sel = 1'b0;

    start_op(32'hDEAD_BEEF, 32'h0102_0304);
    discard = exp_q.pop_front();
    repeat (7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_ready", 64'(ir), 64'd1);
    check("abort_valid", 64'(ov), 64'd0);
    check("abort_result", res, 64'd0);
    check("abort_busy", 64'(bz), 64'd0);
    seen_valid = 1'b0;
    repeat (20) begin
      step();
      seen_valid |= ov;
    end
    check("abort_no_valid", 64'(seen_valid), 64'd0);
    start_op(32'd2, 32'd7);
    wait_done();
    finish_op(0);

    start_op(32'hCAFE_F00D, 32'h89AB_CDEF);
    discard = exp_q.pop_front();
    repeat (10) step();
    #2 rstn = 1'b0;
    #1;
    check("midrst_ready", 64'(ir), 64'd1);
    check("midrst_valid", 64'(ov), 64'd0);
    check("midrst_busy", 64'(bz), 64'd0);
    check("midrst_result", res, 64'd0);
    check("midrst_mul_in0", 64'(mi0), 64'd0);
    check("midrst_mul_in1", 64'(mi1), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    seen_valid = 1'b0;
    repeat (20) begin
      step();
      seen_valid |= ov;
    end
    check("midrst_no_valid", 64'(seen_valid), 64'd0);
    start_op(32'd100, 32'd3);
    wait_done();
    finish_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
